ram_arbiter: RTL and testbench

- Two-port access controller in front of the 256 x 8 level-sensitive RAM (combinational read, level write strobe).
- Shares the RAM between requester 0 (CPU load/store unit) and requester 1 (I/O/DMA engine) using registered req/ack handshakes.
- Sequences every write as setup, strobe, release, so address and data are always stable whenever the RAM write strobe is high.
- Arbitration is round-robin by default; a fixed-priority option is available.

---
 rtl/ram_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_ram_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
//
// Purpose:
//   Shares one level-sensitive RAM (combinational read, level write strobe)
//   between two requesters using registered req/ack handshakes.
//   Requester 0 is the CPU load/store unit and requester 1 is the I/O/DMA
//   engine.
//
//   Every write follows a setup, strobe and release sequence. Address and
//   data are therefore stable for a full cycle on each side of the write
//   strobe.
//
//   Ties between the requesters are broken round-robin by default. Setting
//   FIXED_PRIORITY makes requester 0 win every tie.
//
// Ports:
//   clock, reset          system clock; synchronous active-high reset
//   req0/we0/addr0/wdata0 requester 0 request, write enable, address, data
//   ack0, rdata0          requester 0 completion pulse and read data
//   req1/we1/addr1/wdata1 requester 1 request, write enable, address, data
//   ack1, rdata1          requester 1 completion pulse and read data
//   grant                 one-hot current owner (00 when idle)
//   busy                  high whenever the controller is not idle
//   ram_address           RAM address
//   ram_write             RAM write strobe
//   ram_write_data        RAM write data
//   ram_data              RAM read data
//
// Timing, counted from the edge that accepts a request:
//   read  : ack in the 2nd cycle after the accepting edge
//   write : ack in the 4th cycle after the accepting edge
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module ram_arbiter #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  ack0,
    output logic [DATA_WIDTH-1:0] rdata0,

    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata1,

    output logic [1:0]            grant,
    output logic                  busy,

    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_write,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    input  logic [DATA_WIDTH-1:0] ram_data
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t                  r_state;
    logic                    r_we;
    logic                    r_last_grant;   // 0 = requester 0 won last, 1 = requester 1
    logic [1:0]              r_grant;
    logic                    r_busy;
    logic                    r_ack0;
    logic                    r_ack1;
    logic [DATA_WIDTH-1:0]   r_rdata0;
    logic [DATA_WIDTH-1:0]   r_rdata1;
    logic [ADDR_WIDTH-1:0]   r_ram_address;
    logic                    r_ram_write;
    logic [DATA_WIDTH-1:0]   r_ram_write_data;

    // A request is ignored in the cycle that carries its own ack. This stops
    // a requester that is still holding req from being served twice for one
    // access. The other requester can still be granted in that cycle, which
    // gives back-to-back service with no idle gap.
    logic                    w_req0_eff;
    logic                    w_req1_eff;
    logic                    w_any_req;
    logic                    w_tie;
    logic                    w_pick1;
    logic                    w_sel_we;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_wdata;

    assign w_req0_eff = req0 & ~r_ack0;
    assign w_req1_eff = req1 & ~r_ack1;
    assign w_any_req  = w_req0_eff | w_req1_eff;
    assign w_tie      = w_req0_eff & w_req1_eff;

    // Tie-break: with round-robin, pick the requester that did not win last
    // time. With fixed priority, requester 0 always wins the tie.
    always_comb begin
        w_pick1 = w_req1_eff;
        if (w_tie) begin
            if (FIXED_PRIORITY != 0) begin
                w_pick1 = 1'b0;
            end else begin
                w_pick1 = ~r_last_grant;
            end
        end
    end

    assign w_sel_we    = w_pick1 ? we1    : we0;
    assign w_sel_addr  = w_pick1 ? addr1  : addr0;
    assign w_sel_wdata = w_pick1 ? wdata1 : wdata0;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_we             <= 1'b0;
            r_last_grant     <= 1'b1;
            r_grant          <= 2'b00;
            r_busy           <= 1'b0;
            r_ack0           <= 1'b0;
            r_ack1           <= 1'b0;
            r_rdata0         <= '0;
            r_rdata1         <= '0;
            r_ram_address    <= '0;
            r_ram_write      <= 1'b0;
            r_ram_write_data <= '0;
        end else begin
            // Acks and the write strobe are single-cycle pulses by default.
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_ram_write <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        // Address and data change only on this edge, so
                        // they are frozen for the rest of the access.
                        r_ram_address    <= w_sel_addr;
                        r_ram_write_data <= w_sel_wdata;
                        r_we             <= w_sel_we;
                        r_grant          <= w_pick1 ? 2'b10 : 2'b01;
                        r_last_grant     <= w_pick1;
                        r_busy           <= 1'b1;
                        r_state          <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    if (!r_we) begin
                        // The RAM has had a full cycle to settle on the
                        // address, so its read data is captured here.
                        if (r_grant[1]) begin
                            r_rdata1 <= ram_data;
                            r_ack1   <= 1'b1;
                        end else begin
                            r_rdata0 <= ram_data;
                            r_ack0   <= 1'b1;
                        end
                        r_grant <= 2'b00;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_ram_write <= 1'b1;
                        r_state     <= ST_STROBE;
                    end
                end

                ST_STROBE: begin
                    // The strobe drops here, one cycle after it rose, while
                    // address and data stay put through HOLD.
                    r_state <= ST_HOLD;
                end

                ST_HOLD: begin
                    if (r_grant[1]) begin
                        r_ack1 <= 1'b1;
                    end else begin
                        r_ack0 <= 1'b1;
                    end
                    r_grant <= 2'b00;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_grant <= 2'b00;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack0           = r_ack0;
    assign ack1           = r_ack1;
    assign rdata0         = r_rdata0;
    assign rdata1         = r_rdata1;
    assign grant          = r_grant;
    assign busy           = r_busy;
    assign ram_address    = r_ram_address;
    assign ram_write      = r_ram_write;
    assign ram_write_data = r_ram_write_data;

`ifndef SYNTHESIS
    // Interface invariants.
    a_strobe_single : assert property (@(posedge clock) disable iff (reset)
        r_ram_write |=> !r_ram_write);
    a_addr_stable   : assert property (@(posedge clock) disable iff (reset)
        r_ram_write |=> ($stable(r_ram_address) && $stable(r_ram_write_data)));
    a_ack_exclusive : assert property (@(posedge clock)
        !(r_ack0 && r_ack1));
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, we0, req1, we1;
    logic [7:0] addr0, wdata0, addr1, wdata1;

    // Instance A: round-robin
    logic       ack0_a, ack1_a, busy_a, ram_write_a;
    logic [7:0] rdata0_a, rdata1_a, ram_address_a, ram_write_data_a, ram_data_a;
    logic [1:0] grant_a;
    logic [7:0] ram_a [0:255];

    // Instance B: fixed priority
    logic       ack0_b, ack1_b, busy_b, ram_write_b;
    logic [7:0] rdata0_b, rdata1_b, ram_address_b, ram_write_data_b, ram_data_b;
    logic [1:0] grant_b;
    logic [7:0] ram_b [0:255];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .FIXED_PRIORITY(0)) u_rr (
        .clock(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0_a), .rdata0(rdata0_a),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1_a), .rdata1(rdata1_a),
        .grant(grant_a), .busy(busy_a),
        .ram_address(ram_address_a), .ram_write(ram_write_a),
        .ram_write_data(ram_write_data_a), .ram_data(ram_data_a)
    );

    ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .FIXED_PRIORITY(1)) u_fp (
        .clock(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0_b), .rdata0(rdata0_b),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1_b), .rdata1(rdata1_b),
        .grant(grant_b), .busy(busy_b),
        .ram_address(ram_address_b), .ram_write(ram_write_b),
        .ram_write_data(ram_write_data_b), .ram_data(ram_data_b)
    );

    // RAM models: combinational read, write while the strobe is high
    assign ram_data_a = ram_a[ram_address_a];
    assign ram_data_b = ram_b[ram_address_b];

    always @(posedge clk) begin
        if (ram_write_a) ram_a[ram_address_a] <= ram_write_data_a;
        if (ram_write_b) ram_b[ram_address_b] <= ram_write_data_b;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one access on requester p (instance A observed).
    // The request is held until the ack and dropped in the ack cycle.
    task automatic access(input int p, input logic we, input logic [7:0] a,
                          input logic [7:0] d, input int exp_lat,
                          input logic [7:0] exp_rd, input string tag);
        int         lat;
        int         nstrobe;
        logic [7:0] s_addr;
        logic [7:0] s_data;
        logic       got_ack;

        lat     = 0;
        nstrobe = 0;
        s_addr  = 8'h00;
        s_data  = 8'h00;
        got_ack = 1'b0;

        if (p == 0) begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
        end

        for (int c = 1; c <= 8 && !got_ack; c++) begin
            tick();
            if (c == 1) check({tag, "_grant"}, 32'(grant_a), (p == 0) ? 32'h1 : 32'h2);
            if (ram_write_a) begin
                nstrobe++;
                s_addr = ram_address_a;
                s_data = ram_write_data_a;
            end
            if ((p == 0 && ack0_a) || (p == 1 && ack1_a)) begin
                got_ack = 1'b1;
                lat     = c;
            end
        end

        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_strobes"}, 32'(nstrobe), we ? 32'h1 : 32'h0);
        if (we) begin
            check({tag, "_waddr"}, 32'(s_addr), 32'(a));
            check({tag, "_wdata"}, 32'(s_data), 32'(d));
        end else begin
            check({tag, "_rdata"}, (p == 0) ? 32'(rdata0_a) : 32'(rdata1_a), 32'(exp_rd));
        end

        if (p == 0) req0 = 1'b0; else req1 = 1'b0;
        tick();
        check({tag, "_idle"}, {30'b0, busy_a, ram_write_a}, 32'h0);
    endtask

    // Expected {grant, ack1, ack0} per cycle with both requests held
    logic [3:0] exp_rr [0:7];
    logic [3:0] exp_fp [0:7];
    // Expected {grant, ack0, busy} per cycle with req0 held through its ack
    logic [3:0] exp_hold [0:5];

    initial begin
        logic ack1_seen;

        for (int i = 0; i < 256; i++) begin
            ram_a[i] <= 8'h00;
            ram_b[i] <= 8'h00;
        end
        ram_a[8'h10] <= 8'h5A; ram_b[8'h10] <= 8'h5A;
        ram_a[8'h30] <= 8'h11; ram_b[8'h30] <= 8'h11;
        ram_a[8'h31] <= 8'h22; ram_b[8'h31] <= 8'h22;

        exp_rr = '{4'b10_0_0, 4'b00_1_0, 4'b01_0_0, 4'b00_0_1,
                   4'b10_0_0, 4'b00_1_0, 4'b01_0_0, 4'b00_0_1};
        exp_fp = '{4'b01_0_0, 4'b00_0_1, 4'b10_0_0, 4'b00_1_0,
                   4'b01_0_0, 4'b00_0_1, 4'b10_0_0, 4'b00_1_0};
        exp_hold = '{4'b01_0_1, 4'b00_1_0, 4'b00_0_0, 4'b01_0_1,
                     4'b00_1_0, 4'b00_0_0};

        reset = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00;
        req1 = 1'b0; we1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;

        // Reset state
        tick();
        tick();
        check("rst_ctrl", {26'b0, grant_a, busy_a, ram_write_a, ack0_a, ack1_a}, 32'h0);
        check("rst_data", {8'b0, ram_address_a, ram_write_data_a, rdata0_a}, 32'h0);
        check("rst_rdata1", 32'(rdata1_a), 32'h0);
        reset = 1'b0;

        // Single read, single write, read-back of the written location
        access(0, 1'b0, 8'h10, 8'h00, 2, 8'h5A, "rd10");
        access(1, 1'b1, 8'hFF, 8'hC3, 4, 8'h00, "wrFF");
        check("wr_keeps_rdata0", 32'(rdata0_a), 32'h5A);
        check("wr_keeps_rdata1", 32'(rdata1_a), 32'h0);
        access(0, 1'b0, 8'hFF, 8'h00, 2, 8'hC3, "rdFF");

        // Both held continuously; requester 0 won last, so round-robin
        // starts with requester 1 while fixed priority starts with 0
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h30;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h31;
        for (int c = 0; c < 8; c++) begin
            tick();
            check($sformatf("rr_cyc%0d", c + 1), {28'b0, grant_a, ack1_a, ack0_a}, 32'(exp_rr[c]));
            check($sformatf("fp_cyc%0d", c + 1), {28'b0, grant_b, ack1_b, ack0_b}, 32'(exp_fp[c]));
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        check("both_idle", {28'b0, grant_a, grant_b}, 32'h0);
        check("rr_rdata", {16'b0, rdata0_a, rdata1_a}, 32'h1122);
        check("fp_rdata", {16'b0, rdata0_b, rdata1_b}, 32'h1122);

        // Reset during the write strobe drops the transaction
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h20; wdata1 = 8'h77;
        tick();
        check("rstw_setup", {30'b0, grant_a}, 32'h2);
        tick();
        check("rstw_strobe", {23'b0, ram_write_a, ram_address_a}, 32'h120);
        reset = 1'b1;
        req1  = 1'b0;
        tick();
        check("rstw_after", {27'b0, ram_write_a, busy_a, grant_a, ack1_a}, 32'h0);
        reset = 1'b0;
        ack1_seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (ack1_a || busy_a) ack1_seen = 1'b1;
        end
        check("rstw_no_ack", {31'b0, ack1_seen}, 32'h0);

        // req0 held through its ack cycle: no grant at the ack-cycle edge,
        // then a fresh grant on the following edge
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
        for (int c = 0; c < 6; c++) begin
            tick();
            check($sformatf("hold_cyc%0d", c + 1), {28'b0, grant_a, ack0_a, busy_a}, 32'(exp_hold[c]));
            if (c == 4) begin
                check("hold_rdata0", 32'(rdata0_a), 32'h5A);
                req0 = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
